// File: rtl/aes_pkg.sv
// Shared AES core definitions: controller state encoding and block constants.
// Imported by the controller and its acknowledge timer.
package aes_pkg;

  localparam int AES_WORD_W    = 32;
  localparam int AES_BLOCK_W   = 128;
  localparam int AES128_ROUNDS = 10;

  typedef enum logic [2:0] {
    CTRL_IDLE      = 3'd0,
    CTRL_KEY_START = 3'd1,
    CTRL_KEY_ACK   = 3'd2,
    CTRL_KEY_BUSY  = 3'd3,
    CTRL_ENC_START = 3'd4,
    CTRL_ENC_ACK   = 3'd5,
    CTRL_ENC_BUSY  = 3'd6
  } ctrl_state_t;

  function automatic logic ctrl_is_enc(ctrl_state_t s);
    return (s == CTRL_ENC_START) ||
           (s == CTRL_ENC_ACK) ||
           (s == CTRL_ENC_BUSY);
  endfunction

endpackage

// File: rtl/aes_ack_timer.sv
// Acknowledge timeout counter: clr zeroes it, en counts, expired flags ACK_TIMEOUT cycles.
// Ports: clk, reset (async active-low), clr, en, expired.
module aes_ack_timer
  import aes_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0 is the first waiting cycle, so LAST marks the final one.
  assign expired = (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/aes_core_ctrl.sv
// AES-128 core sequencer: runs key expansion / encryption one at a time, owns the shared S-box mux.
// Ports: host init/next/ready/result_valid/key_valid/error, unit handshakes, S-box mux; AES_CTRL_CYCLE_CNT_EN adds cycle_count.
module aes_core_ctrl
  import aes_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  next,
  output logic                  ready,
  output logic                  result_valid,
  output logic                  key_valid,
  output logic                  error,
  output logic                  key_init,
  input  logic                  key_ready,
  output logic                  enc_next,
  input  logic                  enc_ready,
  input  logic [AES_WORD_W-1:0] key_before_sub,
  input  logic [AES_WORD_W-1:0] enc_before_sub,
  output logic [AES_WORD_W-1:0] sbox_in,
  output logic                  sbox_sel
`ifdef AES_CTRL_CYCLE_CNT_EN
  ,
  output logic [31:0]           cycle_count
`endif
);

  ctrl_state_t state;
  ctrl_state_t state_d;

  logic pending;
  logic pending_d;
  logic ready_d;
  logic rv_d;
  logic kv_d;
  logic err_d;
  logic tmr_clr;
  logic tmr_en;
  logic expired;

  assign tmr_clr = (state == CTRL_KEY_START) ||
                   (state == CTRL_ENC_START);
  assign tmr_en  = (state == CTRL_KEY_ACK) ||
                   (state == CTRL_ENC_ACK);

  aes_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_ack_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= CTRL_IDLE;
      pending      <= 1'b0;
      ready        <= 1'b1;
      result_valid <= 1'b0;
      key_valid    <= 1'b0;
      error        <= 1'b0;
      key_init     <= 1'b0;
      enc_next     <= 1'b0;
    end else begin
      state        <= state_d;
      pending      <= pending_d;
      ready        <= ready_d;
      result_valid <= rv_d;
      key_valid    <= kv_d;
      error        <= err_d;
      key_init     <= (state_d == CTRL_KEY_START);
      enc_next     <= (state_d == CTRL_ENC_START);
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      CTRL_IDLE: begin
        if (init) begin
          state_d = CTRL_KEY_START;
        end else if (next && key_valid) begin
          state_d = CTRL_ENC_START;
        end
      end
      CTRL_KEY_START: state_d = CTRL_KEY_ACK;
      CTRL_KEY_ACK: begin
        if (!key_ready) begin
          state_d = CTRL_KEY_BUSY;
        end else if (expired) begin
          state_d = CTRL_IDLE;
        end
      end
      CTRL_KEY_BUSY: begin
        if (key_ready) begin
          state_d = pending ? CTRL_ENC_START : CTRL_IDLE;
        end
      end
      CTRL_ENC_START: state_d = CTRL_ENC_ACK;
      CTRL_ENC_ACK: begin
        if (!enc_ready) begin
          state_d = CTRL_ENC_BUSY;
        end else if (expired) begin
          state_d = CTRL_IDLE;
        end
      end
      CTRL_ENC_BUSY: begin
        if (enc_ready) begin
          state_d = CTRL_IDLE;
        end
      end
      default: state_d = CTRL_IDLE;
    endcase
  end

  always_comb begin
    pending_d = pending;
    ready_d   = ready;
    rv_d      = result_valid;
    kv_d      = key_valid;
    err_d     = error;
    unique case (state)
      CTRL_IDLE: begin
        if (init) begin
          ready_d   = 1'b0;
          kv_d      = 1'b0;
          rv_d      = 1'b0;
          err_d     = 1'b0;
          pending_d = next;
        end else if (next && key_valid) begin
          ready_d = 1'b0;
          rv_d    = 1'b0;
        end
      end
      CTRL_KEY_ACK,
      CTRL_ENC_ACK: begin
        // Unit never acknowledged: give up and drop any queued next.
        if ((state == CTRL_KEY_ACK ? key_ready : enc_ready) && expired) begin
          err_d     = 1'b1;
          ready_d   = 1'b1;
          pending_d = 1'b0;
        end
      end
      CTRL_KEY_BUSY: begin
        if (key_ready) begin
          kv_d = 1'b1;
          if (pending) begin
            pending_d = 1'b0;
          end else begin
            ready_d = 1'b1;
          end
        end
      end
      CTRL_ENC_BUSY: begin
        if (enc_ready) begin
          rv_d    = 1'b1;
          ready_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign sbox_sel = ctrl_is_enc(state);
  assign sbox_in  = sbox_sel ? enc_before_sub : key_before_sub;

`ifdef AES_CTRL_CYCLE_CNT_EN
  logic enc_run;

  assign enc_run = (state == CTRL_ENC_ACK) ||
                   (state == CTRL_ENC_BUSY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
    end else if (state_d == CTRL_ENC_START) begin
      cycle_count <= '0;
    end else if (enc_run && (cycle_count != '1)) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aes_core_ctrl.sv
// Self-checking bench for aes_core_ctrl: transaction-level unit models with random latencies.
// Checks start pulses, completion latencies, sticky error, S-box ownership and async reset.
module tb_aes_core_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic        next;
  logic        ready;
  logic        result_valid;
  logic        key_valid;
  logic        error;
  logic        key_init;
  logic        key_ready;
  logic        enc_next;
  logic        enc_ready;
  logic [31:0] key_before_sub;
  logic [31:0] enc_before_sub;
  logic [31:0] sbox_in;
  logic        sbox_sel;
`ifdef AES_CTRL_CYCLE_CNT_EN
  logic [31:0] cycle_count;
`endif

  aes_core_ctrl #(
    .ACK_TIMEOUT(TO),
    .CNT_W      (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .next          (next),
    .ready         (ready),
    .result_valid  (result_valid),
    .key_valid     (key_valid),
    .error         (error),
    .key_init      (key_init),
    .key_ready     (key_ready),
    .enc_next      (enc_next),
    .enc_ready     (enc_ready),
    .key_before_sub(key_before_sub),
    .enc_before_sub(enc_before_sub),
    .sbox_in       (sbox_in),
    .sbox_sel      (sbox_sel)
`ifdef AES_CTRL_CYCLE_CNT_EN
    ,
    .cycle_count   (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int kt = -1;
  int et = -1;
  int klo = 1;
  int kbusy = 8;
  int elo = 1;
  int ebusy = 8;
  bit kstuck = 0;
  bit fix_enc = 0;
  int n_kinit = 0;
  int n_enext = 0;
  int t_enext = 0;
  bit kv_m = 0;
  bit rv_m = 0;
  bit err_m = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: observe at negedge, then advance the unit models.
  task automatic tick();
    bit exp_sel;
    @(negedge clk);
    cyc++;
    init = 1'b0;
    next = 1'b0;
    exp_sel = enc_next || (et >= 0);
    check("sbox_sel", {31'd0, sbox_sel}, {31'd0, exp_sel});
    check("sbox_in", sbox_in, exp_sel ? enc_before_sub : key_before_sub);
    if (key_init) n_kinit++;
    if (enc_next) begin
      n_enext++;
      t_enext = cyc;
    end
    if (key_init) kt = 0;
    else if (kt >= 0) kt++;
    key_ready = kstuck || !(kt >= klo && kt < klo + kbusy);
    if (kt >= klo + kbusy) kt = -1;
    if (enc_next) et = 0;
    else if (et >= 0) et++;
    enc_ready = !(et >= elo && et < elo + ebusy);
    if (et >= elo + ebusy) et = -1;
    key_before_sub = $urandom;
    enc_before_sub = fix_enc ? 32'hDEADBEEF : $urandom;
  endtask

  task automatic wait_ready(int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready && n < budget);
    check("wait_ready", {31'd0, ready}, 32'd1);
  endtask

  task automatic run_cmd(bit i, bit n, bit inject,
                         int kl, int kb, int el, int eb);
    int k0;
    int exp_k;
    int exp_e;
    int lat;
    bit acc;
    bit do_enc;
    klo = kl;
    kbusy = kb;
    elo = el;
    ebusy = eb;
    exp_k = n_kinit;
    exp_e = n_enext;
    acc = i || (n && kv_m);
    do_enc = n && (i || kv_m);
    init = i;
    next = n;
    tick();
    if (!acc) begin
      repeat (3) tick();
      check("ign ready", {31'd0, ready}, 32'd1);
      check("ign error", {31'd0, error}, {31'd0, err_m});
      check("ign rv", {31'd0, result_valid}, {31'd0, rv_m});
      check("ign kinit", n_kinit, exp_k);
      check("ign enext", n_enext, exp_e);
      return;
    end
    k0 = cyc;
    if (i) begin
      exp_k++;
      kv_m = 0;
      err_m = 0;
      check("start kinit", {31'd0, key_init}, 32'd1);
      check("err clr", {31'd0, error}, 32'd0);
      check("kv clr", {31'd0, key_valid}, 32'd0);
    end else begin
      check("start enext", {31'd0, enc_next}, 32'd1);
    end
    if (do_enc) exp_e++;
    rv_m = 0;
    check("start ready", {31'd0, ready}, 32'd0);
    check("start rv", {31'd0, result_valid}, 32'd0);
    tick();
    check("pulse width", {31'd0, key_init | enc_next}, 32'd0);
    if (inject) begin
      tick();
      init = 1'b1;
      next = 1'b1;
    end
    wait_ready(400);
    lat = 0;
    if (i) lat += kl + kb + 1;
    if (do_enc) lat += el + eb + 1;
    check("latency", cyc - k0, lat);
    if (i && n) check("pend delay", t_enext - k0, kl + kb + 1);
    if (i) kv_m = 1;
    if (do_enc) rv_m = 1;
    check("done kv", {31'd0, key_valid}, {31'd0, kv_m});
    check("done rv", {31'd0, result_valid}, {31'd0, rv_m});
    check("done err", {31'd0, error}, 32'd0);
    check("n kinit", n_kinit, exp_k);
    check("n enext", n_enext, exp_e);
`ifdef AES_CTRL_CYCLE_CNT_EN
    if (do_enc) begin
      check("cyc cnt", cycle_count, el + eb);
      repeat (2) tick();
      check("cyc hold", cycle_count, el + eb);
    end
`endif
  endtask

  initial begin
    int k0;
    int pk;
    int pe;
    reset = 1'b0;
    init = 1'b0;
    next = 1'b0;
    key_ready = 1'b1;
    enc_ready = 1'b1;
    key_before_sub = $urandom;
    enc_before_sub = $urandom;
    repeat (3) tick();
    check("rst ready", {31'd0, ready}, 32'd1);
    check("rst rv", {31'd0, result_valid}, 32'd0);
    check("rst kv", {31'd0, key_valid}, 32'd0);
    check("rst err", {31'd0, error}, 32'd0);
    check("rst kinit", {31'd0, key_init}, 32'd0);
    check("rst enext", {31'd0, enc_next}, 32'd0);
    reset = 1'b1;
    tick();

    run_cmd(1, 0, 0, 3, 40, 1, 8);
    run_cmd(0, 1, 0, 1, 8, 2, 50);
    run_cmd(1, 1, 0, 4, 20, 3, 30);

    // Key unit never acknowledges: sticky error after the timeout.
    kstuck = 1;
    init = 1'b1;
    tick();
    k0 = cyc;
    check("to kinit", {31'd0, key_init}, 32'd1);
    wait_ready(100);
    check("to latency", cyc - k0, TO + 1);
    check("to error", {31'd0, error}, 32'd1);
    check("to kv", {31'd0, key_valid}, 32'd0);
    kstuck = 0;
    kt = -1;
    kv_m = 0;
    rv_m = 0;
    err_m = 1;
    run_cmd(0, 1, 0, 1, 8, 1, 8);
    run_cmd(1, 0, 0, 2, 12, 1, 8);

    // Reset in the middle of an encryption.
    fix_enc = 1;
    elo = 2;
    ebusy = 50;
    pk = n_kinit;
    pe = n_enext;
    next = 1'b1;
    tick();
    check("r enext", {31'd0, enc_next}, 32'd1);
    repeat (10) tick();
    check("r sbox", sbox_in, 32'hDEADBEEF);
    init = 1'b1;
    next = 1'b1;
    repeat (4) tick();
    check("r n kinit", n_kinit, pk);
    check("r n enext", n_enext, pe + 1);
    #2 reset = 1'b0;
    #1;
    check("ar ready", {31'd0, ready}, 32'd1);
    check("ar rv", {31'd0, result_valid}, 32'd0);
    check("ar kv", {31'd0, key_valid}, 32'd0);
    check("ar err", {31'd0, error}, 32'd0);
    check("ar enext", {31'd0, enc_next}, 32'd0);
    check("ar sel", {31'd0, sbox_sel}, 32'd0);
    check("ar sbox", sbox_in, key_before_sub);
`ifdef AES_CTRL_CYCLE_CNT_EN
    check("ar cyc", cycle_count, 32'd0);
`endif
    fix_enc = 0;
    kt = -1;
    et = -1;
    key_ready = 1'b1;
    enc_ready = 1'b1;
    kv_m = 0;
    rv_m = 0;
    err_m = 0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    run_cmd(0, 1, 0, 1, 8, 1, 8);

    for (int r = 0; r < 30; r++) begin
      run_cmd($urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1,
              $urandom_range(1, 8), $urandom_range(8, 40),
              $urandom_range(1, 8), $urandom_range(8, 60));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
